mul_fault_arbiter: RTL
======================

# mul_fault_arbiter

- Shares one fault-detecting GF(2^N) multiplier (`mul_fault`) between two requesters, e.g. the coordinate-translation stage and the point-arithmetic sequencer.
- Round-robin arbitration; one multiplication in flight at a time.
- Watches the multiplier's `ERROR` flag and re-issues a faulted multiplication up to a bounded retry count.
- Returns each result to its owner with a fault flag; a watchdog guards against a multiplier that never answers.

## Interface
- `N`, 233, field width of operands and result.
- `MAX_RETRY`, 2, re-issues allowed after an `ERROR` result (0 = no retry).
- `TIMEOUT`, 1023, maximum cycles spent in `WAIT` before the operation is abandoned.
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `REQ0_VALID`, `REQ1_VALID`  in  1  requester has operands pending.
- `REQ0_A`, `REQ0_B`, `REQ1_A`, `REQ1_B`  in  N  operands.
- `REQ0_READY`, `REQ1_READY`  out  1  request accepted this cycle.
- `RSP0_VALID`, `RSP1_VALID`  out  1  one-cycle result strobe.
- `RSP_DOUT`  out  N  result, shared by both responders, meaningful while an `RSPx_VALID` is high.
- `RSP_FAULT`  out  1  result unreliable (persistent `ERROR` or timeout), qualified by `RSPx_VALID`.
- `MUL_IN_VALID`  out  1  one-cycle start pulse to the multiplier.
- `MUL_A`, `MUL_B`  out  N  latched operands, held stable from issue until the response.
- `MUL_DOUT`  in  N  multiplier product.
- `MUL_OUT_VALID`  in  1  product valid.
- `MUL_ERROR`  in  1  fault detected, qualified by `MUL_OUT_VALID`.

## Operation
- **States:** `IDLE`, `ISSUE`, `WAIT`, `RESP`.
- **IDLE, grant:**
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the one indicated by the priority pointer `prio`.
  - `REQx_READY` is combinational: it is high only in `IDLE` for the granted requester.
- **IDLE, accept:** on the `READY & VALID` edge, latch A, B and the owner id; clear the retry and timeout counters; go to `ISSUE`.
- **ISSUE:** `MUL_IN_VALID` = 1 for exactly one cycle, then go to `WAIT`.
- **WAIT, counting:** the timeout counter increments every cycle.
- **WAIT, `MUL_OUT_VALID` = 1:**
  - If `MUL_ERROR` = 1 and retries < `MAX_RETRY`: increment retries, clear the timeout counter, go to `ISSUE`.
  - Otherwise: register `RSP_DOUT` = `MUL_DOUT` and `RSP_FAULT` = `MUL_ERROR`, then go to `RESP`.
- **WAIT, timeout:** when the counter reaches `TIMEOUT` without `MUL_OUT_VALID`, register `RSP_DOUT` = 0 and `RSP_FAULT` = 1, then go to `RESP`.
- **RESP:**
  - The owner's `RSPx_VALID` = 1 for one cycle; responses have no backpressure.
  - `prio` is set to the other requester.
  - Go to `IDLE`.
- **Stray responses:** `MUL_OUT_VALID` seen outside `WAIT` is ignored.
- **Timeout and response on the same cycle:** the response wins.
- **Request inputs while busy:** changes to `REQx_VALID` outside `IDLE` have no effect; the requester keeps `VALID` high until `READY`.
- **Reset (at any time, including mid-operation):**
  - State returns to `IDLE`; `prio` = 0.
  - All registered outputs, latched operands and counters are cleared to 0.
  - Any in-flight multiplier result is discarded.

## Timing
- **Issue:** handshake at edge k; `MUL_IN_VALID` high in cycle k+1.
- **Response latency:** with multiplier latency L (`MUL_OUT_VALID` in cycle k+1+L), `RSPx_VALID` is high in cycle k+2+L.
- **Retry cost:** each retry adds L+1 cycles.
- **Throughput:** `READY` can be high again in cycle k+3+L, back-to-back with the response cycle.
- **Outputs:** all outputs are registered except `REQx_READY`.

## Configuration
- **Macro `MUL_FAULT_RETRY_EN`:**
  - Defined: retry behaviour as described above.
  - Undefined: `MAX_RETRY` is ignored, the retry counter is not built, and the first `MUL_OUT_VALID` always goes to `RESP` with `RSP_FAULT` = `MUL_ERROR`.
- The timeout is always present.

## Structure
- **Shared package `ecc_pkg`:**
  - field width constant `N_FIELD` = 233;
  - state enum (`IDLE`, `ISSUE`, `WAIT`, `RESP`);
  - requester-id typedef (1 bit).
- **Sub-module `rr_arb2`:** two-input round-robin grant logic (valid pair, `prio` → one-hot grant). Everything else lives in the top.

## Test plan
- Bench model: multiplier with L = 4, `MAX_RETRY` = 2, `TIMEOUT` = 20.
- **Single request:** `REQ0` A=3, B=5, no error → `RSP0_VALID` at k+6, `RSP_DOUT` = 0xF (GF(2) product), `RSP_FAULT` = 0.
- **Contention:** `REQ0` and `REQ1` both valid from reset → `REQ0` granted first, `REQ1` granted in the cycle after `RSP0_VALID`; order alternates 0,1,0,1 while both stay valid.
- **Transient fault:** `MUL_ERROR` on the first result only → two `MUL_IN_VALID` pulses, `RSP` at k+11, `RSP_FAULT` = 0.
- **Persistent fault:** `MUL_ERROR` on every result → three issues, then `RSP_FAULT` = 1. With the macro undefined: one issue, then `RSP_FAULT` = 1.
- **Timeout:** model never answers → `RSP_VALID` 21 cycles after issue, `RSP_DOUT` = 0, `RSP_FAULT` = 1; a late `MUL_OUT_VALID` afterwards is ignored.
- **Reset mid-WAIT:**
  - Assert `RST_N` = 0 → all outputs 0 immediately.
  - After release, `REQ1` alone → granted at the first `IDLE` cycle.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the multiplier arbitration slice: field width,
// arbiter state encoding and requester identifiers.
package ecc_pkg;

  localparam int unsigned N_FIELD = 233;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef logic req_id_t;

  // The requester that is not `id`; used to rotate priority after a response.
  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mul_fault_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the shared
// fault-detecting multiplier. The master view is the arbiter; the slave
// view is the surrounding environment (requesters plus multiplier).
interface mul_fault_arbiter_if
  import ecc_pkg::*;
#(
  parameter int unsigned N = N_FIELD
);

  logic         REQ0_VALID;
  logic         REQ1_VALID;
  logic [N-1:0] REQ0_A;
  logic [N-1:0] REQ0_B;
  logic [N-1:0] REQ1_A;
  logic [N-1:0] REQ1_B;
  logic         REQ0_READY;
  logic         REQ1_READY;

  logic         RSP0_VALID;
  logic         RSP1_VALID;
  logic [N-1:0] RSP_DOUT;
  logic         RSP_FAULT;

  logic         MUL_IN_VALID;
  logic [N-1:0] MUL_A;
  logic [N-1:0] MUL_B;
  logic [N-1:0] MUL_DOUT;
  logic         MUL_OUT_VALID;
  logic         MUL_ERROR;

  modport master (
    input  REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
    output REQ0_READY, REQ1_READY,
    output RSP0_VALID, RSP1_VALID, RSP_DOUT, RSP_FAULT,
    output MUL_IN_VALID, MUL_A, MUL_B,
    input  MUL_DOUT, MUL_OUT_VALID, MUL_ERROR
  );

  modport slave (
    output REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
    input  REQ0_READY, REQ1_READY,
    input  RSP0_VALID, RSP1_VALID, RSP_DOUT, RSP_FAULT,
    input  MUL_IN_VALID, MUL_A, MUL_B,
    output MUL_DOUT, MUL_OUT_VALID, MUL_ERROR
  );

endinterface

// File: rtl/mul_fault_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone valid requester always wins, and on
// contention the priority pointer picks the winner. Grant is one-hot or zero.
module rr_arb2
  import ecc_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_t    prio_i,
  output logic [1:0] gnt_o
);

  // Grant follows the valid pair unless both are set, then priority decides.
  always_comb begin
    gnt_o = valid_i;
    if (valid_i == 2'b11) begin
      gnt_o = (prio_i == 1'b1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mul_fault_arbiter.sv
// Shares one fault-detecting GF(2^N) multiplier between two requesters.
// Round-robin grant, one multiplication in flight, bounded re-issue on
// multiplier ERROR, and a watchdog that abandons a silent multiplier.
// Build option: define MUL_FAULT_RETRY_EN to enable re-issue on ERROR;
// without it the first multiplier response is always final.
module mul_fault_arbiter
  import ecc_pkg::*;
#(
  parameter int unsigned N         = N_FIELD,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input logic                 CLK,
  input logic                 RST_N,
  mul_fault_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t       state_q;
  req_id_t      prio_q;
  req_id_t      owner_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] rsp_dout_q;
  logic         rsp_fault_q;
  logic         rsp0_valid_q;
  logic         rsp1_valid_q;
  logic         mul_in_valid_q;
  logic [CW-1:0] tmo_q;
  logic [CW-1:0] tmo_d;

  logic [1:0]   gnt;
  logic         accept;
  logic         retry_ok;
  logic         retry_take;
  logic         timeout_hit;

  rr_arb2 u_arb (
    .valid_i ({bus.REQ1_VALID, bus.REQ0_VALID}),
    .prio_i  (prio_q),
    .gnt_o   (gnt)
  );

  assign bus.REQ0_READY   = (state_q == IDLE) && gnt[0];
  assign bus.REQ1_READY   = (state_q == IDLE) && gnt[1];
  assign bus.RSP0_VALID   = rsp0_valid_q;
  assign bus.RSP1_VALID   = rsp1_valid_q;
  assign bus.RSP_DOUT     = rsp_dout_q;
  assign bus.RSP_FAULT    = rsp_fault_q;
  assign bus.MUL_IN_VALID = mul_in_valid_q;
  assign bus.MUL_A        = a_q;
  assign bus.MUL_B        = b_q;

  assign accept      = (state_q == IDLE) && (gnt != 2'b00);
  assign tmo_d       = tmo_q + CW'(1);
  // Fires on the WAIT cycle whose increment would reach TIMEOUT, so WAIT
  // lasts at most TIMEOUT cycles.
  assign timeout_hit = (tmo_d == CW'(TIMEOUT));
  assign retry_take  = (state_q == WAIT) && bus.MUL_OUT_VALID && bus.MUL_ERROR && retry_ok;

`ifdef MUL_FAULT_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0] retry_q;

  assign retry_ok = (retry_q < RW'(MAX_RETRY));

  // Re-issue counter: cleared per accepted request, bumped on each re-issue.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retry_q <= '0;
    end else if (accept) begin
      retry_q <= '0;
    end else if (retry_take) begin
      retry_q <= retry_q + RW'(1);
    end
  end
`else
  // MAX_RETRY stays in the parameter list for drop-in compatibility; this
  // build never re-issues.
  assign retry_ok = 1'b0 & (MAX_RETRY > 0);
`endif

  // Arbiter FSM with registered multiplier and response outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= IDLE;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      rsp_dout_q     <= '0;
      rsp_fault_q    <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      mul_in_valid_q <= 1'b0;
      tmo_q          <= '0;
    end else begin
      mul_in_valid_q <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q            <= gnt[1] ? bus.REQ1_A : bus.REQ0_A;
            b_q            <= gnt[1] ? bus.REQ1_B : bus.REQ0_B;
            owner_q        <= gnt[1];
            tmo_q          <= '0;
            mul_in_valid_q <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          // A response on the timeout cycle takes precedence over the watchdog.
          if (bus.MUL_OUT_VALID) begin
            if (retry_take) begin
              tmo_q          <= '0;
              mul_in_valid_q <= 1'b1;
              state_q        <= ISSUE;
            end else begin
              rsp_dout_q   <= bus.MUL_DOUT;
              rsp_fault_q  <= bus.MUL_ERROR;
              rsp0_valid_q <= (owner_q == 1'b0);
              rsp1_valid_q <= (owner_q == 1'b1);
              state_q      <= RESP;
            end
          end else if (timeout_hit) begin
            rsp_dout_q   <= '0;
            rsp_fault_q  <= 1'b1;
            rsp0_valid_q <= (owner_q == 1'b0);
            rsp1_valid_q <= (owner_q == 1'b1);
            state_q      <= RESP;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        RESP: begin
          prio_q  <= other_req(owner_q);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
